accel_tilt_filter: RTL

ACCEL_TILT_FILTER -- requirements
Module: accel_tilt_filter

---
 rtl/accel_tilt_filter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/accel_tilt_filter.sv
// Two-axis accelerometer smoother: 8-sample moving average per axis, sampled on a
// prescaled tick, with hysteretic tilt / face-down flags derived from the averages.
module accel_tilt_filter #(
   parameter int                 SAMPLE_DIV = 100000,
   parameter logic signed [15:0] THRESH     = 16'sd200,
   parameter logic signed [15:0] HYST       = 16'sd50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] Y_value,
   input  logic [15:0] Z_value,
   output logic [15:0] Y_avg,
   output logic [15:0] Z_avg,
   output logic        avg_valid,
   output logic        tilt_pos_y,
   output logic        tilt_neg_y,
   output logic        face_down,
   output logic [1:0]  dbg_state
);

   localparam int              CW      = $clog2(SAMPLE_DIV);
   localparam logic [CW-1:0]   CNT_MAX = CW'(SAMPLE_DIV - 1);
   localparam logic signed [15:0] POS_ON  = THRESH;
   localparam logic signed [15:0] POS_OFF = THRESH - HYST;
   localparam logic signed [15:0] NEG_ON  = -THRESH;
   localparam logic signed [15:0] NEG_OFF = -(THRESH - HYST);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_UPDATE, S_OUTPUT} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [15:0]        ys_q, ys_d, zs_q, zs_d;
   logic [15:0]        win_y_q [8];
   logic [15:0]        win_y_d [8];
   logic [15:0]        win_z_q [8];
   logic [15:0]        win_z_d [8];
   logic signed [18:0] sum_y_q, sum_y_d, sum_z_q, sum_z_d;
   logic [2:0]         ptr_q, ptr_d;
   logic [3:0]         fill_q, fill_d;
   logic [15:0]        y_avg_q, y_avg_d, z_avg_q, z_avg_d;
   logic               valid_q, valid_d;
   logic               pos_q, pos_d, neg_q, neg_d, fd_q, fd_d;
   logic               tick;
   logic signed [15:0] y_new, z_new;

   assign tick  = (cnt_q == CNT_MAX);
   // New averages are taken from the sums that UPDATE just wrote.
   assign y_new = sum_y_q[18:3];
   assign z_new = sum_z_q[18:3];

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      ys_d    = ys_q;
      zs_d    = zs_q;
      win_y_d = win_y_q;
      win_z_d = win_z_q;
      sum_y_d = sum_y_q;
      sum_z_d = sum_z_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      y_avg_d = y_avg_q;
      z_avg_d = z_avg_q;
      valid_d = 1'b0;
      pos_d   = pos_q;
      neg_d   = neg_q;
      fd_d    = fd_q;
      case (state_q)
         S_IDLE: if (tick) state_d = S_CAPTURE;
         S_CAPTURE: begin
            ys_d    = Y_value;
            zs_d    = Z_value;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            sum_y_d = sum_y_q + {{3{ys_q[15]}}, ys_q} - {{3{win_y_q[ptr_q][15]}}, win_y_q[ptr_q]};
            sum_z_d = sum_z_q + {{3{zs_q[15]}}, zs_q} - {{3{win_z_q[ptr_q][15]}}, win_z_q[ptr_q]};
            win_y_d[ptr_q] = ys_q;
            win_z_d[ptr_q] = zs_q;
            ptr_d   = ptr_q + 3'd1;
            if (fill_q != 4'd8) fill_d = fill_q + 4'd1;
            state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (fill_q == 4'd8) begin
               y_avg_d = y_new;
               z_avg_d = z_new;
               valid_d = 1'b1;
               if (y_new > POS_ON) pos_d = 1'b1;
               else if (y_new < POS_OFF) pos_d = 1'b0;
               if (y_new < NEG_ON) neg_d = 1'b1;
               else if (y_new > NEG_OFF) neg_d = 1'b0;
               if (z_new < NEG_ON) fd_d = 1'b1;
               else if (z_new > NEG_OFF) fd_d = 1'b0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ys_q    <= '0;
         zs_q    <= '0;
         for (int i = 0; i < 8; i++) begin
            win_y_q[i] <= '0;
            win_z_q[i] <= '0;
         end
         sum_y_q <= '0;
         sum_z_q <= '0;
         ptr_q   <= '0;
         fill_q  <= '0;
         y_avg_q <= '0;
         z_avg_q <= '0;
         valid_q <= 1'b0;
         pos_q   <= 1'b0;
         neg_q   <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ys_q    <= ys_d;
         zs_q    <= zs_d;
         win_y_q <= win_y_d;
         win_z_q <= win_z_d;
         sum_y_q <= sum_y_d;
         sum_z_q <= sum_z_d;
         ptr_q   <= ptr_d;
         fill_q  <= fill_d;
         y_avg_q <= y_avg_d;
         z_avg_q <= z_avg_d;
         valid_q <= valid_d;
         pos_q   <= pos_d;
         neg_q   <= neg_d;
         fd_q    <= fd_d;
      end
   end

   assign Y_avg      = y_avg_q;
   assign Z_avg      = z_avg_q;
   assign avg_valid  = valid_q;
   assign tilt_pos_y = pos_q;
   assign tilt_neg_y = neg_q;
   assign face_down  = fd_q;
   assign dbg_state  = state_q;

endmodule
